// File: rtl/qdrc_phy_burst_align_if.sv
// Sequencer-facing handshake and QDR data/control bundle for qdrc_phy_burst_align.
interface qdrc_phy_burst_align_if #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 21
);
    logic                  burst_align_start;
    logic                  burst_align_done;
    logic                  burst_align_fail;
    logic                  qdr_w_n;
    logic                  qdr_r_n;
    logic [ADDR_WIDTH-1:0] qdr_sa;
    logic [DATA_WIDTH-1:0] qdr_d_rise;
    logic [DATA_WIDTH-1:0] qdr_d_fall;
    logic [DATA_WIDTH-1:0] qdr_q_rise;
    logic [DATA_WIDTH-1:0] qdr_q_fall;
    logic [3:0]            burst_align_latency;
    logic                  burst_align_swap;
    logic [2:0]            burst_state_prb;

    modport master (
        output burst_align_start, qdr_q_rise, qdr_q_fall,
        input  burst_align_done, burst_align_fail, qdr_w_n, qdr_r_n, qdr_sa,
               qdr_d_rise, qdr_d_fall, burst_align_latency, burst_align_swap,
               burst_state_prb
    );

    modport slave (
        input  burst_align_start, qdr_q_rise, qdr_q_fall,
        output burst_align_done, burst_align_fail, qdr_w_n, qdr_r_n, qdr_sa,
               qdr_d_rise, qdr_d_fall, burst_align_latency, burst_align_swap,
               burst_state_prb
    );
endinterface

// File: rtl/qdrc_phy_burst_align.sv
// QDR burst alignment responder: writes a known burst, reads it back, finds latency and slot swap.
// Optional QDRC_BURST_ALIGN_RETRY_EN: up to three write/read attempts before reporting failure.
module qdrc_phy_burst_align #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 21,
    parameter int TIMEOUT    = 15
) (
    input logic                   clk,
    input logic                   reset,
    qdrc_phy_burst_align_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        GAP     = 3'd2,
        READ    = 3'd3,
        SEARCH  = 3'd4,
        CONFIRM = 3'd5,
        DONE    = 3'd6
    } state_t;

    function automatic logic [DATA_WIDTH-1:0] alt_pattern();
        logic [DATA_WIDTH-1:0] p;
        p = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) p[i] = i[0];
        return p;
    endfunction

    localparam logic [DATA_WIDTH-1:0] PAT_R = '1;
    localparam logic [DATA_WIDTH-1:0] PAT_F = alt_pattern();

    state_t     state;
    logic [3:0] cnt;
    logic       gap_second;
    logic       full_match;
    logic       fall_match;
    logic       attempt_fail;
`ifdef QDRC_BURST_ALIGN_RETRY_EN
    logic [1:0] attempt;
`endif

    always_comb begin
        full_match   = (bus.qdr_q_rise == PAT_R) && (bus.qdr_q_fall == PAT_F);
        fall_match   = (bus.qdr_q_fall == PAT_R);
        attempt_fail = 1'b0;
        if (state == SEARCH && !full_match && !fall_match && cnt == 4'(TIMEOUT - 1))
            attempt_fail = 1'b1;
        if (state == CONFIRM && bus.qdr_q_rise != PAT_F)
            attempt_fail = 1'b1;
    end

    assign bus.qdr_sa          = '0;
    assign bus.burst_state_prb = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                   <= IDLE;
            cnt                     <= '0;
            gap_second              <= 1'b0;
            bus.burst_align_done    <= 1'b0;
            bus.burst_align_fail    <= 1'b0;
            bus.qdr_w_n             <= 1'b1;
            bus.qdr_r_n             <= 1'b1;
            bus.qdr_d_rise          <= '0;
            bus.qdr_d_fall          <= '0;
            bus.burst_align_latency <= '0;
            bus.burst_align_swap    <= 1'b0;
`ifdef QDRC_BURST_ALIGN_RETRY_EN
            attempt                 <= '0;
`endif
        end else begin
            bus.burst_align_done <= 1'b0;
            bus.qdr_w_n          <= 1'b1;
            bus.qdr_r_n          <= 1'b1;
            bus.qdr_d_rise       <= '0;
            bus.qdr_d_fall       <= '0;
            case (state)
                IDLE: begin
                    if (bus.burst_align_start) begin
                        state                   <= WRITE;
                        bus.burst_align_fail    <= 1'b0;
                        bus.burst_align_latency <= '0;
                        bus.burst_align_swap    <= 1'b0;
                        bus.qdr_w_n             <= 1'b0;
                        bus.qdr_d_rise          <= PAT_R;
                        bus.qdr_d_fall          <= PAT_F;
`ifdef QDRC_BURST_ALIGN_RETRY_EN
                        attempt                 <= '0;
`endif
                    end
                end
                WRITE: begin
                    state      <= GAP;
                    gap_second <= 1'b0;
                end
                GAP: begin
                    if (gap_second) begin
                        state       <= READ;
                        bus.qdr_r_n <= 1'b0;
                    end else begin
                        gap_second <= 1'b1;
                    end
                end
                READ: begin
                    state <= SEARCH;
                    cnt   <= '0;
                end
                SEARCH: begin
                    if (full_match) begin
                        bus.burst_align_latency <= cnt;
                        bus.burst_align_swap    <= 1'b0;
                        bus.burst_align_done    <= 1'b1;
                        state                   <= DONE;
                    end else if (fall_match) begin
                        bus.burst_align_latency <= cnt;
                        bus.burst_align_swap    <= 1'b1;
                        state                   <= CONFIRM;
                    end else if (!attempt_fail) begin
                        cnt <= cnt + 4'd1;
                    end
                end
                CONFIRM: begin
                    if (!attempt_fail) begin
                        bus.burst_align_done <= 1'b1;
                        state                <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            // Failure exits from SEARCH and CONFIRM share one path so retry sits in one place.
            if (attempt_fail) begin
`ifdef QDRC_BURST_ALIGN_RETRY_EN
                if (attempt != 2'd2) begin
                    attempt        <= attempt + 2'd1;
                    state          <= WRITE;
                    bus.qdr_w_n    <= 1'b0;
                    bus.qdr_d_rise <= PAT_R;
                    bus.qdr_d_fall <= PAT_F;
                end else begin
                    bus.burst_align_fail <= 1'b1;
                    bus.burst_align_done <= 1'b1;
                    state                <= DONE;
                end
`else
                bus.burst_align_fail <= 1'b1;
                bus.burst_align_done <= 1'b1;
                state                <= DONE;
`endif
            end
        end
    end
endmodule

// File: tb/tb_qdrc_phy_burst_align.sv
// Directed bench for qdrc_phy_burst_align with a QDR read-return model.
module tb_qdrc_phy_burst_align;
    localparam int M_NONE  = 0;
    localparam int M_ALIGN = 1;
    localparam int M_SWAP  = 2;
    localparam int M_BAD   = 3;
`ifdef QDRC_BURST_ALIGN_RETRY_EN
    localparam int ATT = 3;
`else
    localparam int ATT = 1;
`endif

    typedef struct {
        string name;
        int    mode;
        int    lat;
        int    restart_at;
        int    exp_done;
        logic  exp_fail;
        int    exp_lat;
        logic  exp_swap;
        int    exp_writes;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   model_mode = M_NONE;
    int   model_lat = 0;
    int   k = 1000;
    vec_t vecs[8];

    qdrc_phy_burst_align_if #(.DATA_WIDTH(18), .ADDR_WIDTH(21)) bus();

    qdrc_phy_burst_align #(.DATA_WIDTH(18), .ADDR_WIDTH(21), .TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // k counts cycles since the read strobe; k==0 is the first SEARCH cycle.
    always @(posedge clk) begin
        if (!bus.qdr_r_n) k <= 0;
        else              k <= k + 1;
    end

    always_comb begin
        bus.qdr_q_rise = '0;
        bus.qdr_q_fall = '0;
        case (model_mode)
            M_ALIGN: if (k == model_lat) begin
                bus.qdr_q_rise = 18'h3FFFF;
                bus.qdr_q_fall = 18'h2AAAA;
            end
            M_SWAP: begin
                if (k == model_lat)     bus.qdr_q_fall = 18'h3FFFF;
                if (k == model_lat + 1) bus.qdr_q_rise = 18'h2AAAA;
            end
            M_BAD: begin
                if (k == model_lat)     bus.qdr_q_fall = 18'h3FFFF;
                if (k == model_lat + 1) bus.qdr_q_rise = 18'h12345;
            end
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int writes;
        int got;
        writes = 0;
        got    = 0;
        @(negedge clk);
        model_mode = v.mode;
        model_lat  = v.lat;
        bus.burst_align_start = 1'b1;
        @(posedge clk);
        #1;
        bus.burst_align_start = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
                bus.burst_align_start = 1'b0;
            end
            if (c == 1) begin
                chk({v.name, ".fail_clr"}, 32'(bus.burst_align_fail), 32'd0);
                chk({v.name, ".w_n"}, 32'(bus.qdr_w_n), 32'd0);
                chk({v.name, ".d_rise"}, 32'(bus.qdr_d_rise), 32'h3FFFF);
                chk({v.name, ".d_fall"}, 32'(bus.qdr_d_fall), 32'h2AAAA);
                chk({v.name, ".sa"}, 32'(bus.qdr_sa), 32'd0);
            end
            if (c == 2) chk({v.name, ".gap_d"}, 32'({bus.qdr_w_n, bus.qdr_d_rise}), 32'h40000);
            if (c == v.restart_at) bus.burst_align_start = 1'b1;
            if (!bus.qdr_w_n) writes++;
            if (bus.burst_align_done) begin
                got = c;
                break;
            end
        end
        chk({v.name, ".done_cyc"}, 32'(got), 32'(v.exp_done));
        chk({v.name, ".fail"}, 32'(bus.burst_align_fail), 32'(v.exp_fail));
        chk({v.name, ".latency"}, 32'(bus.burst_align_latency), 32'(v.exp_lat));
        chk({v.name, ".swap"}, 32'(bus.burst_align_swap), 32'(v.exp_swap));
        chk({v.name, ".writes"}, 32'(writes), 32'(v.exp_writes));
        @(posedge clk);
        #1;
        chk({v.name, ".done_pulse"}, 32'(bus.burst_align_done), 32'd0);
        chk({v.name, ".idle"}, 32'(bus.burst_state_prb), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk({v.name, ".fail_hold"}, 32'(bus.burst_align_fail), 32'(v.exp_fail));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        vecs[0] = '{"align3",   M_ALIGN, 3,  0, 9,           1'b0, 3,  1'b0, 1};
        vecs[1] = '{"align0",   M_ALIGN, 0,  0, 6,           1'b0, 0,  1'b0, 1};
        vecs[2] = '{"swap2",    M_SWAP,  2,  0, 9,           1'b0, 2,  1'b1, 1};
        vecs[3] = '{"timeout",  M_NONE,  0,  0, 1 + ATT*19,  1'b1, 0,  1'b0, ATT};
        vecs[4] = '{"badconf",  M_BAD,   2,  0, 1 + ATT*8,   1'b1, 2,  1'b1, ATT};
        vecs[5] = '{"align14",  M_ALIGN, 14, 0, 20,          1'b0, 14, 1'b0, 1};
        vecs[6] = '{"swap13",   M_SWAP,  13, 0, 20,          1'b0, 13, 1'b1, 1};
        vecs[7] = '{"gapstart", M_ALIGN, 1,  2, 7,           1'b0, 1,  1'b0, 1};

        bus.burst_align_start = 1'b0;
        #12;
        chk("rst.done", 32'(bus.burst_align_done), 32'd0);
        chk("rst.outs", 32'({bus.burst_align_fail, bus.qdr_w_n, bus.qdr_r_n, bus.burst_align_swap}), 32'b0110);
        chk("rst.d", 32'(bus.qdr_d_rise | bus.qdr_d_fall), 32'd0);
        chk("rst.lat_state", 32'({bus.burst_align_latency, bus.burst_state_prb}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset asserted mid-SEARCH: outputs clear at once and no done follows.
        @(negedge clk);
        model_mode = M_NONE;
        bus.burst_align_start = 1'b1;
        @(posedge clk);
        #1;
        bus.burst_align_start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("mid.search", 32'(bus.burst_state_prb), 32'd4);
        #2;
        reset = 1'b1;
        #1;
        chk("mid.state", 32'(bus.burst_state_prb), 32'd0);
        chk("mid.outs", 32'({bus.burst_align_done, bus.burst_align_fail, bus.qdr_w_n, bus.qdr_r_n}), 32'b0011);
        chk("mid.lat_swap", 32'({bus.burst_align_latency, bus.burst_align_swap}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (bus.burst_align_done) dones++;
        end
        chk("mid.no_done", 32'(dones), 32'd0);
        chk("mid.idle", 32'(bus.burst_state_prb), 32'd0);

        run_vec(vecs[7]);
        run_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
